// File: rtl/ro_freq_meter.sv
// Wishbone-readable ring-oscillator frequency meter: counts rising edges of one
// selected oscillator-mux output over a programmable window of wb_clk_i cycles.
module ro_freq_meter #(
  parameter int unsigned NUM_CH    = 5,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] GATE_RST  = 32'd1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_CH-1:0] ro_in,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned DW       = 32;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned PAD_W    = 8;
  localparam int unsigned ARM_W    = 3;
  localparam int unsigned ARM_CYC  = 3;
  localparam int unsigned REARM_CYC = 4;

  localparam logic [1:0] R_CTRL  = 2'd0;
  localparam logic [1:0] R_GATE  = 2'd1;
  localparam logic [1:0] R_COUNT = 2'd2;
  localparam logic [1:0] R_STAT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    COUNT_ST = 2'd2,
    DONE_ST  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               ack_q, ack_d;
  logic [DW-1:0]      rdat_q, rdat_d;
  logic               ctrl_cont_q, ctrl_cont_d;
  logic [SEL_W-1:0]   ctrl_sel_q, ctrl_sel_d;
  logic [DW-1:0]      gate_q, gate_d;
  logic [DW-1:0]      count_q, count_d;
  logic               st_done_q, st_done_d;
  logic               st_ovf_q, st_ovf_d;
  logic [SEL_W-1:0]   sel_w_q, sel_w_d;
  logic [DW-1:0]      gate_cnt_q, gate_cnt_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [DW-1:0]      accum_q, accum_d;
  logic [2:0]         sync_q, sync_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               hit_c, acc_c, wr_c, start_c, edge_c;
  logic [1:0]         reg_idx_c;
  logic [PAD_W-1:0]   ro_pad_c;
  logic [DW-1:0]      gate_eff_c;
  logic               unused_c;

  // Bus decode; writes commit in the ack cycle while the master still holds the bus
  assign hit_c      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc_c      = wbs_stb_i & wbs_cyc_i & hit_c & ~ack_q;
  assign wr_c       = wbs_stb_i & wbs_cyc_i & hit_c & ack_q & wbs_we_i;
  assign reg_idx_c  = wbs_adr_i[3:2];
  assign start_c    = wr_c & (reg_idx_c == R_CTRL) & wbs_sel_i[0] & wbs_dat_i[0];
  assign ro_pad_c   = PAD_W'(ro_in);
  assign edge_c     = sync_q[1] & ~sync_q[2];
  assign gate_eff_c = (gate_q == '0) ? DW'(1) : gate_q;
  assign unused_c   = ^wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      ctrl_cont_q <= 1'b0;
      ctrl_sel_q  <= '0;
      gate_q      <= GATE_RST;
      count_q     <= '0;
      st_done_q   <= 1'b0;
      st_ovf_q    <= 1'b0;
      sel_w_q     <= '0;
      gate_cnt_q  <= '0;
      arm_cnt_q   <= '0;
      accum_q     <= '0;
      sync_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdat_q      <= rdat_d;
      ctrl_cont_q <= ctrl_cont_d;
      ctrl_sel_q  <= ctrl_sel_d;
      gate_q      <= gate_d;
      count_q     <= count_d;
      st_done_q   <= st_done_d;
      st_ovf_q    <= st_ovf_d;
      sel_w_q     <= sel_w_d;
      gate_cnt_q  <= gate_cnt_d;
      arm_cnt_q   <= arm_cnt_d;
      accum_q     <= accum_d;
      sync_q      <= sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = acc_c;
    rdat_d      = '0;
    ctrl_cont_d = ctrl_cont_q;
    ctrl_sel_d  = ctrl_sel_q;
    gate_d      = gate_q;
    count_d     = count_q;
    st_done_d   = st_done_q;
    st_ovf_d    = st_ovf_q;
    sel_w_d     = sel_w_q;
    gate_cnt_d  = gate_cnt_q;
    arm_cnt_d   = arm_cnt_q;
    accum_d     = accum_q;
    sync_d      = {sync_q[1:0], ro_pad_c[sel_w_q]};

    if (acc_c && !wbs_we_i) begin
      case (reg_idx_c)
        R_CTRL:  rdat_d = DW'({ctrl_sel_q, 2'b00, ctrl_cont_q, 1'b0});
        R_GATE:  rdat_d = gate_q;
        R_COUNT: rdat_d = count_q;
        default: rdat_d = DW'({st_ovf_q, st_done_q, busy_q});
      endcase
    end

    if (wr_c) begin
      case (reg_idx_c)
        R_CTRL: begin
          if (wbs_sel_i[0]) begin
            ctrl_cont_d = wbs_dat_i[1];
            ctrl_sel_d  = wbs_dat_i[6:4];
          end
        end
        R_GATE: begin
          for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) gate_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
          end
        end
        R_STAT: begin
          if (wbs_sel_i[0] && wbs_dat_i[1]) st_done_d = 1'b0;
          if (wbs_sel_i[0] && wbs_dat_i[2]) st_ovf_d  = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start_c) begin
          sel_w_d    = ctrl_sel_d;
          gate_cnt_d = gate_eff_c;
          arm_cnt_d  = ARM_W'(ARM_CYC);
          st_ovf_d   = 1'b0;
          accum_d    = '0;
          state_d    = ARM;
        end
      end
      ARM: begin
        if (arm_cnt_q <= ARM_W'(1)) state_d = COUNT_ST;
        else                        arm_cnt_d = arm_cnt_q - ARM_W'(1);
      end
      COUNT_ST: begin
        if (edge_c) begin
          if (accum_q == '1) st_ovf_d = 1'b1;
          else               accum_d  = accum_q + DW'(1);
        end
        if (gate_cnt_q <= DW'(1)) state_d = DONE_ST;
        else                      gate_cnt_d = gate_cnt_q - DW'(1);
      end
      DONE_ST: begin
        count_d   = accum_q;
        st_done_d = 1'b1;
        accum_d   = '0;
        if (ctrl_cont_q) begin
          // Re-arm holds one extra cycle so the freshly switched mux settles before the flush
          sel_w_d    = ctrl_sel_d;
          gate_cnt_d = gate_eff_c;
          arm_cnt_d  = ARM_W'(REARM_CYC);
          state_d    = ARM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE_ST);
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
Wishbone-readable frequency meter that measures the ring-oscillator outputs driven off-chip through the mux16x1_project outputs.
- Counts rising edges of one selected oscillator-mux output over a programmable gate window of wb_clk_i cycles.
- Exposes the count to the management SoC so firmware can characterise each oscillator without an external counter.
- Sits in user_project_wrapper beside the mux instances, on the Wishbone slave port.

Parameters:
- NUM_CH, 5, number of oscillator-mux inputs on ro_in (one per mux instance).
- BASE_ADDR, 32'h3000_0000, base address; wbs_adr_i[31:4] must equal BASE_ADDR[31:4] to decode.
- GATE_RST, 32'd1024, reset value of the GATE register.

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_i  input  1  reset, synchronous, active-high.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte lanes; writes honour them per byte.
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  address.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- ro_in  input  NUM_CH  asynchronous oscillator-mux outputs.
- busy_o  output  1  measurement in progress.
- done_o  output  1  one-cycle pulse when a window completes.

Behaviour:
- Register map, decoded on wbs_adr_i[3:2]:
  - 0x0 CTRL:
    - bit0 START: write-1 launches a measurement; reads 0.
    - bit1 CONT: continuous mode.
    - bits[6:4] SEL: channel select.
  - 0x4 GATE: window length in clocks; a stored value of 0 is treated as 1.
  - 0x8 COUNT: read-only; result of the last completed window.
  - 0xC STATUS:
    - bit0 BUSY.
    - bit1 DONE: sticky, write-1-to-clear.
    - bit2 OVF: sticky, write-1-to-clear.
- Wishbone handshake:
  - ack asserts for exactly one cycle, in the cycle after stb&cyc is seen with ack low; back-to-back accesses therefore take 2 cycles each.
  - Address mismatch: no ack.
  - Writes to COUNT are acked and ignored.
  - Reads of unmapped bits return 0.
  - wbs_dat_o is 0 whenever ack is low.
- Reset: all of the following go to 0:
  - outputs wbs_ack_o, wbs_dat_o, busy_o, done_o;
  - registers CTRL, COUNT, STATUS;
  - synchronizer and edge flops;
  - FSM state, which returns to IDLE.
  - GATE resets to GATE_RST.
  - Reset mid-measurement aborts the window; COUNT reads 0.
- Input path:
  - ro_in[SEL_latched] passes through a 2-flop synchronizer plus an edge flop.
  - Edge = sync2 & ~sync3.
  - Guaranteed accurate for input frequency < f_clk/2; faster inputs alias, and that is not flagged.
- FSM:
  - IDLE: on START write (ack cycle), latch SEL and GATE into working copies, clear OVF, set BUSY → ARM.
  - ARM: 3 cycles to flush the synchronizer; edges are not counted → COUNT_ST; the gate counter loads the working GATE.
  - COUNT_ST: each cycle, edge increments the 32-bit accumulator and the gate counter decrements. When the gate counter reaches 1, that cycle's edge is included → DONE_ST.
  - DONE_ST, one cycle:
    - COUNT ← accumulator;
    - set DONE;
    - done_o = 1;
    - clear the accumulator.
    - If CONT=1 → ARM, re-latching SEL/GATE and keeping BUSY high. Otherwise clear BUSY → IDLE.
- Accumulator saturates at 32'hFFFF_FFFF and sets OVF.
- START written while BUSY: ignored; the rest of the CTRL write takes effect, but a SEL change applies only at the next latch.
- Clearing CONT mid-window: the current window completes, then the FSM goes to IDLE.
- W1C of DONE in the same cycle DONE_ST sets it: the set wins.
- A COUNT read coinciding with its update returns the old value.

Test Plan:
- Reset → read GATE=1024, CTRL=0, COUNT=0, STATUS=0; wbs_ack_o low until the first access.
- Square wave period 10 clocks on ro_in[2], SEL=2, GATE=1000, START:
  - BUSY visible until done_o;
  - COUNT=100 ±1;
  - STATUS=0x2.
- Same setup with GATE=0:
  - window of 1 clock; COUNT ∈ {0,1};
  - done_o fires 5 cycles after the START ack (ARM 3 + COUNT 1 + DONE 1).
- CONT=1 with a period-4 input, GATE=400:
  - successive done_o pulses are 405 cycles apart; each COUNT=100 ±1.
  - Clear CONT → exactly one more window, then BUSY=0.
- Assert wb_rst_i mid-window, then release → all registers at reset values. START a second time while busy → no restart and done_o timing unchanged.
- Wishbone edge cases, each returning a one-cycle ack:
  - write with wbs_sel_i=4'b0001 to GATE changes only byte 0;
  - access with wrong upper address → no ack within 8 cycles;
  - W1C of DONE clears it.
